// File: rtl/compare_score_tracker.sv
// Score keeper placed after the 4-bit magnitude comparator.
// It counts A wins, B wins and ties, detects win streaks and ends the match
// when a player reaches TARGET.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   cmp_valid           one-cycle strobe, comparator flags valid
//   equal, a_big, b_big comparator flags
//   clear               synchronous match restart (same effect as rst)
//   score_a, score_b    rounds won by A / B
//   ties                tied rounds, saturating
//   leader              00 level, 01 A ahead, 10 B ahead
//   game_over, winner   match ended; 01 A won, 10 B won
//   streak_flag         one-cycle pulse when a streak reaches STREAK_LEN
//   err                 sticky, illegal flag combination seen
module compare_score_tracker #(
    parameter int CNT_W      = 4,
    parameter int TARGET     = 9,
    parameter int STREAK_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_valid,
    input  logic             equal,
    input  logic             a_big,
    input  logic             b_big,
    input  logic             clear,
    output logic [CNT_W-1:0] score_a,
    output logic [CNT_W-1:0] score_b,
    output logic [CNT_W-1:0] ties,
    output logic [1:0]       leader,
    output logic             game_over,
    output logic [1:0]       winner,
    output logic             streak_flag,
    output logic             err
);

    localparam int SW = $clog2(STREAK_LEN + 1);

    localparam logic [SW-1:0]    SLEN  = SW'(STREAK_LEN);
    localparam logic [SW-1:0]    S_ONE = SW'(1);
    localparam logic [CNT_W-1:0] TGT   = CNT_W'(TARGET);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX = '1;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state;
    logic [SW-1:0] streak_cnt;
    logic [1:0]    streak_own;

    logic             legal;
    logic             take;
    logic             inc_a;
    logic             inc_b;
    logic             inc_t;
    logic [CNT_W-1:0] sa_n;
    logic [CNT_W-1:0] sb_n;
    logic [CNT_W-1:0] ties_n;
    logic [1:0]       leader_n;
    logic [SW-1:0]    cnt_n;
    logic [1:0]       own_n;
    logic             pulse;
    logic             win_a;
    logic             win_b;

    always_comb begin
        legal  = cmp_valid && $onehot({equal, a_big, b_big});
        take   = legal && (state != DONE);
        inc_a  = take && a_big;
        inc_b  = take && b_big;
        inc_t  = take && equal;

        sa_n   = inc_a ? score_a + C_ONE : score_a;
        sb_n   = inc_b ? score_b + C_ONE : score_b;
        ties_n = (inc_t && ties != C_MAX) ? ties + C_ONE : ties;

        if (sa_n > sb_n)
            leader_n = 2'b01;
        else if (sb_n > sa_n)
            leader_n = 2'b10;
        else
            leader_n = 2'b00;

        cnt_n = streak_cnt;
        own_n = streak_own;
        if (inc_a || inc_b) begin
            if (streak_own == (inc_a ? OWN_A : OWN_B)) begin
                if (streak_cnt != SLEN)
                    cnt_n = streak_cnt + S_ONE;
            end else begin
                own_n = inc_a ? OWN_A : OWN_B;
                cnt_n = S_ONE;
            end
        end else if (inc_t) begin
            own_n = OWN_NONE;
            cnt_n = '0;
        end

        // Pulse only on the transition into SLEN, not while saturated.
        pulse = (cnt_n == SLEN) && (streak_cnt != SLEN);

        win_a = inc_a && (sa_n == TGT);
        win_b = inc_b && (sb_n == TGT);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= IDLE;
            score_a     <= '0;
            score_b     <= '0;
            ties        <= '0;
            leader      <= 2'b00;
            game_over   <= 1'b0;
            winner      <= 2'b00;
            streak_flag <= 1'b0;
            err         <= 1'b0;
            streak_cnt  <= '0;
            streak_own  <= OWN_NONE;
        end else begin
            streak_flag <= pulse;
            // DONE ignores strobes entirely, including for err.
            if (cmp_valid && state != DONE && !legal)
                err <= 1'b1;
            if (take) begin
                score_a    <= sa_n;
                score_b    <= sb_n;
                ties       <= ties_n;
                leader     <= leader_n;
                streak_cnt <= cnt_n;
                streak_own <= own_n;
                if (win_a || win_b) begin
                    state     <= DONE;
                    game_over <= 1'b1;
                    winner    <= win_a ? 2'b01 : 2'b10;
                end else begin
                    state <= PLAY;
                end
            end
        end
    end

endmodule

// File: tb/tb_compare_score_tracker.sv
// Randomized plus directed bench for compare_score_tracker with a
// queue-based scoreboard and a decoupled monitor.
module tb_compare_score_tracker;

    localparam int CNT_W      = 4;
    localparam int TARGET     = 9;
    localparam int STREAK_LEN = 3;
    localparam int TIE_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmp_valid = 1'b0;
    logic             equal = 1'b0;
    logic             a_big = 1'b0;
    logic             b_big = 1'b0;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] score_a;
    logic [CNT_W-1:0] score_b;
    logic [CNT_W-1:0] ties;
    logic [1:0]       leader;
    logic             game_over;
    logic [1:0]       winner;
    logic             streak_flag;
    logic             err;

    compare_score_tracker #(
        .CNT_W(CNT_W),
        .TARGET(TARGET),
        .STREAK_LEN(STREAK_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmp_valid(cmp_valid),
        .equal(equal),
        .a_big(a_big),
        .b_big(b_big),
        .clear(clear),
        .score_a(score_a),
        .score_b(score_b),
        .ties(ties),
        .leader(leader),
        .game_over(game_over),
        .winner(winner),
        .streak_flag(streak_flag),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sa;
        int sb;
        int t;
        int ld;
        int go;
        int wn;
        int sf;
        int er;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: plain integers, match rules applied directly.
    int m_sa, m_sb, m_t, m_run, m_own, m_win;
    bit m_done, m_err, m_sf;

    task automatic model_reset();
        m_sa = 0; m_sb = 0; m_t = 0;
        m_run = 0; m_own = 0; m_win = 0;
        m_done = 0; m_err = 0; m_sf = 0;
    endtask

    task automatic model_step(input bit r, input bit c, input bit v,
                              input bit e, input bit a, input bit b);
        int n;
        int prev;
        if (r || c) begin
            model_reset();
            return;
        end
        m_sf = 0;
        if (m_done || !v) return;
        n = int'(e) + int'(a) + int'(b);
        if (n != 1) begin
            m_err = 1;
            return;
        end
        if (e) begin
            if (m_t < TIE_MAX) m_t++;
            m_run = 0;
            m_own = 0;
        end else begin
            if (a) m_sa++;
            else m_sb++;
            prev = (m_own == (a ? 1 : 2)) ? m_run : 0;
            m_own = a ? 1 : 2;
            m_run = (prev + 1 > STREAK_LEN) ? STREAK_LEN : prev + 1;
            if (m_run == STREAK_LEN && prev == STREAK_LEN - 1) m_sf = 1;
            if (m_sa == TARGET || m_sb == TARGET) begin
                m_done = 1;
                m_win = a ? 1 : 2;
            end
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit v,
                         input bit e, input bit a, input bit b);
        exp_t x;
        @(negedge clk);
        rst = r; clear = c; cmp_valid = v;
        equal = e; a_big = a; b_big = b;
        model_step(r, c, v, e, a, b);
        x.sa = m_sa; x.sb = m_sb; x.t = m_t;
        x.ld = (m_sa > m_sb) ? 1 : (m_sb > m_sa) ? 2 : 0;
        x.go = int'(m_done); x.wn = m_done ? m_win : 0;
        x.sf = int'(m_sf); x.er = int'(m_err);
        q.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, want);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("score_a", int'(score_a), x.sa);
                chk("score_b", int'(score_b), x.sb);
                chk("ties", int'(ties), x.t);
                chk("leader", int'(leader), x.ld);
                chk("game_over", int'(game_over), x.go);
                chk("winner", int'(winner), x.wn);
                chk("streak_flag", int'(streak_flag), x.sf);
                chk("err", int'(err), x.er);
            end
        end
    end

    initial begin
        int k;
        int wait_cnt;
        bit v, e, a, b, c, r;
        model_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        // Three A wins in a row.
        repeat (3) drive(0, 0, 1, 0, 1, 0);
        // A,A,tie,A,A,A after a clear.
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        // Nine B wins with gaps, then an ignored A strobe in DONE.
        drive(0, 1, 0, 0, 0, 0);
        repeat (9) begin
            drive(0, 0, 1, 0, 0, 1);
            drive(0, 0, 0, 1, 1, 1);
        end
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 1, 1, 0);
        // Illegal flag combinations, then clear.
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 0, 1, 1);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        // Tie saturation.
        repeat (17) drive(0, 0, 1, 1, 0, 0);
        // clear with a_big at score_a=4.
        drive(0, 1, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 0, 1, 0, 1, 0);
        // Finish a match, then rst while in DONE.
        repeat (9) drive(0, 0, 1, 0, 1, 0);
        drive(1, 0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 9);
            v = ($urandom_range(0, 9) < 8);
            e = 0; a = 0; b = 0;
            if (k < 3) a = 1;
            else if (k < 6) b = 1;
            else if (k < 8) e = 1;
            else if (k == 9) begin
                e = 1'($urandom); a = 1'($urandom); b = 1'($urandom);
            end
            c = ($urandom_range(0, 99) < 3);
            r = ($urandom_range(0, 199) == 0);
            drive(r, c, v, e, a, b);
        end
        drive(0, 0, 0, 0, 0, 0);
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
